// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//   Control FSM and BCD mm:ss time base for a 4-digit 7-segment stopwatch.
//   Debounced start/stop and lap/clear button levels are edge-detected and
//   drive IDLE/RUN/LAP/PAUSE sequencing. A prescaler produces one time
//   increment every TICK_DIV cycles while running. The registered digit bus
//   shows either the live time or the frozen lap value.
//
// Ports
//   clk        in   1   clock, rising edge
//   reset      in   1   synchronous, active-high reset
//   btn_ss     in   1   debounced start/stop level; rising edge = press
//   btn_lap    in   1   debounced lap/clear level; rising edge = press
//   disp_bcd   out  16  {m_tens, m_units, s_tens, s_units}, 4-bit BCD each
//   running    out  1   high in RUN and LAP
//   lap_active out  1   high in LAP (display frozen on lap value)
//   tick       out  1   high in the cycle whose closing edge increments time
//   wrap       out  1   high in the cycle whose closing edge rolls 59:59->00:00
//
// Buttons are plain levels, not a valid/ready handshake: a press is the
// first cycle a level is seen high after being low, and it is consumed on
// that same clock edge.
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int TICK_DIV = 10_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_ss,
  input  logic        btn_lap,
  output logic [15:0] disp_bcd,
  output logic        running,
  output logic        lap_active,
  output logic        tick,
  output logic        wrap
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_LAP   = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  state_t        state_q, state_n;
  logic [PW-1:0] presc_q, presc_n;
  logic [15:0]   time_q,  time_n;
  logic [15:0]   lap_q,   lap_n;
  logic [15:0]   disp_q,  disp_n;
  logic [15:0]   time_inc;
  logic          ss_q, lap_btn_q;
  logic          ss_p, lap_p;
  logic          counting;

  // ---------------------------------------------------------------------------
  // Time increment with BCD carry chain: s_units -> s_tens -> m_units -> m_tens.
  // 59:59 naturally rolls to 00:00 because every digit resets at its limit.
  // ---------------------------------------------------------------------------
  always_comb begin
    time_inc = time_q;
    if (time_q[3:0] == 4'd9) begin
      time_inc[3:0] = 4'd0;
      if (time_q[7:4] == 4'd5) begin
        time_inc[7:4] = 4'd0;
        if (time_q[11:8] == 4'd9) begin
          time_inc[11:8] = 4'd0;
          if (time_q[15:12] == 4'd5) time_inc[15:12] = 4'd0;
          else                       time_inc[15:12] = time_q[15:12] + 4'd1;
        end else begin
          time_inc[11:8] = time_q[11:8] + 4'd1;
        end
      end else begin
        time_inc[7:4] = time_q[7:4] + 4'd1;
      end
    end else begin
      time_inc[3:0] = time_q[3:0] + 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    ss_p     = btn_ss & ~ss_q;
    lap_p    = btn_lap & ~lap_btn_q;
    counting = (state_q == S_RUN) || (state_q == S_LAP);
    tick     = counting && (presc_q == PRESC_MAX);
    wrap     = tick && (time_q == 16'h5959);

    state_n  = state_q;
    presc_n  = presc_q;
    time_n   = time_q;
    lap_n    = lap_q;

    // Prescaler runs in RUN and LAP only; PAUSE keeps the partial second.
    if (counting) presc_n = tick ? '0 : presc_q + 1'b1;
    if (tick)     time_n  = time_inc;

    // Start/stop wins over lap when both arrive together; lap is dropped.
    if (ss_p) begin
      case (state_q)
        S_IDLE:  state_n = S_RUN;
        S_RUN:   state_n = S_PAUSE;
        S_LAP:   state_n = S_PAUSE;
        S_PAUSE: state_n = S_RUN;
        default: state_n = S_IDLE;
      endcase
    end else if (lap_p) begin
      case (state_q)
        S_RUN: begin
          state_n = S_LAP;
          lap_n   = time_q;  // pre-increment value even if tick coincides
        end
        S_LAP:   state_n = S_RUN;
        S_PAUSE: begin
          state_n = S_IDLE;
          time_n  = '0;
          presc_n = '0;
        end
        default: state_n = state_q;
      endcase
    end

    // Display is computed from the next state so it changes together with
    // running/lap_active, one cycle after the button rises.
    disp_n = (state_n == S_LAP) ? lap_n : time_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      time_q    <= '0;
      lap_q     <= '0;
      disp_q    <= '0;
      // Start "high" so a button held through reset is not seen as a press.
      ss_q      <= 1'b1;
      lap_btn_q <= 1'b1;
    end else begin
      state_q   <= state_n;
      presc_q   <= presc_n;
      time_q    <= time_n;
      lap_q     <= lap_n;
      disp_q    <= disp_n;
      ss_q      <= btn_ss;
      lap_btn_q <= btn_lap;
    end
  end

  assign disp_bcd   = disp_q;
  assign running    = (state_q == S_RUN) || (state_q == S_LAP);
  assign lap_active = (state_q == S_LAP);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//   Self-checking bench for stopwatch_ctrl with TICK_DIV = 4. A reference
//   model keeps elapsed time as an integer second count and mode as a small
//   integer; expected outputs are pushed into exp_q on every rising edge and
//   compared against the DUT on the following falling edge. Directed
//   scenarios add literal expectations, then a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

  localparam int TICK_DIV = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_ss = 1'b0;
  logic        btn_lap = 1'b0;
  logic [15:0] disp_bcd;
  logic        running, lap_active, tick, wrap;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.TICK_DIV(TICK_DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_ss     (btn_ss),
    .btn_lap    (btn_lap),
    .disp_bcd   (disp_bcd),
    .running    (running),
    .lap_active (lap_active),
    .tick       (tick),
    .wrap       (wrap)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------------------------------------------------------------------
  // Reference model: seconds as an integer 0..3599, mode as an integer.
  // ---------------------------------------------------------------------------
  localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_PAUSE = 3;

  int m_mode = M_IDLE, m_secs = 0, m_lap = 0, m_presc = 0;
  bit m_ss_prev = 1'b1, m_lap_prev = 1'b1;

  logic [19:0] exp_q[$];

  function automatic logic [15:0] to_bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  always @(posedge clk) begin : model_b
    int n_mode, n_secs, n_lap, n_presc;
    bit ss_p, lap_p, live, t, e_run, e_tick;
    n_mode  = m_mode;
    n_secs  = m_secs;
    n_lap   = m_lap;
    n_presc = m_presc;
    if (reset) begin
      n_mode = M_IDLE; n_secs = 0; n_lap = 0; n_presc = 0;
    end else begin
      ss_p  = btn_ss  && !m_ss_prev;
      lap_p = btn_lap && !m_lap_prev;
      live  = (m_mode == M_RUN) || (m_mode == M_LAP);
      t     = live && (m_presc == TICK_DIV - 1);
      if (live) n_presc = t ? 0 : m_presc + 1;
      if (t)    n_secs  = (m_secs + 1) % 3600;
      if (ss_p) begin
        n_mode = live ? M_PAUSE : M_RUN;
      end else if (lap_p) begin
        case (m_mode)
          M_RUN:   begin n_mode = M_LAP; n_lap = m_secs; end
          M_LAP:   n_mode = M_RUN;
          M_PAUSE: begin n_mode = M_IDLE; n_secs = 0; n_presc = 0; end
          default: ;
        endcase
      end
    end
    e_run  = (n_mode == M_RUN) || (n_mode == M_LAP);
    e_tick = e_run && (n_presc == TICK_DIV - 1);
    exp_q.push_back({(n_mode == M_LAP) ? to_bcd(n_lap) : to_bcd(n_secs),
                     e_run, (n_mode == M_LAP), e_tick, e_tick && (n_secs == 3599)});
    m_mode     <= n_mode;
    m_secs     <= n_secs;
    m_lap      <= n_lap;
    m_presc    <= n_presc;
    m_ss_prev  <= reset ? 1'b1 : btn_ss;
    m_lap_prev <= reset ? 1'b1 : btn_lap;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard: every cycle, DUT outputs vs model expectation.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin : compare_b
    logic [19:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {disp_bcd, running, lap_active, tick, wrap};
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL cycle_outputs t=%0t actual disp=%h run=%b lap=%b tick=%b wrap=%b required disp=%h run=%b lap=%b tick=%b wrap=%b",
                    $time, a[19:4], a[3], a[2], a[1], a[0], e[19:4], e[3], e[2], e[1], e[0]);
    end
  end

  // ---------------------------------------------------------------------------
  // Literal checks and driver tasks
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, req);
  endtask

  task automatic press_ss();
    @(posedge clk); #1 btn_ss = 1'b1;
    @(posedge clk); #1 btn_ss = 1'b0;
  endtask

  task automatic press_lap();
    @(posedge clk); #1 btn_lap = 1'b1;
    @(posedge clk); #1 btn_lap = 1'b0;
  endtask

  // Returns on the falling edge where the n-th tick is visible.
  task automatic wait_ticks(input int n);
    int seen, budget;
    seen   = 0;
    budget = n * TICK_DIV * 2 + 20;
    while (seen < n && budget > 0) begin
      @(negedge clk);
      if (tick) seen++;
      budget--;
    end
    if (seen < n) begin
      n_checks++;
      $display("FAIL wait_ticks: saw %0d ticks, required %0d", seen, n);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stim
    int lat, nt;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_disp", disp_bcd, 16'h0000);
    check("reset_flags", {12'd0, running, lap_active, tick, wrap}, 16'h0000);

    // 1: start, tick cadence, 10 seconds
    press_ss();
    @(negedge clk);
    check("start_running", {15'd0, running}, 16'd1);
    lat = 0;
    while (!tick && lat < 10) begin @(negedge clk); lat++; end
    check("first_tick_latency", 16'(lat), 16'd3);
    wait_ticks(9);
    @(negedge clk);
    check("ten_seconds", disp_bcd, 16'h0010);

    // 2: run up to 59:58, then wrap
    wait_ticks(3588);
    @(negedge clk);
    check("preload_5958", disp_bcd, 16'h5958);
    wait_ticks(1);
    check("no_wrap_5958", {15'd0, wrap}, 16'd0);
    @(negedge clk);
    check("show_5959", disp_bcd, 16'h5959);
    wait_ticks(1);
    check("wrap_pulse", {15'd0, wrap}, 16'd1);
    @(negedge clk);
    check("wrapped_0000", disp_bcd, 16'h0000);

    // 3: lap freeze at 00:05, release at 00:09
    wait_ticks(5);
    press_lap();
    @(negedge clk);
    check("lap_active", {15'd0, lap_active}, 16'd1);
    check("lap_frozen", disp_bcd, 16'h0005);
    wait_ticks(4);
    check("lap_still_frozen", disp_bcd, 16'h0005);
    press_lap();
    @(negedge clk);
    check("lap_release", disp_bcd, 16'h0009);
    check("lap_release_flag", {15'd0, lap_active}, 16'd0);

    // 4: pause holds prescaler and time, resume ticks at once, then clear
    press_ss();
    nt = 0;
    repeat (20) begin @(negedge clk); if (tick) nt++; end
    check("pause_no_ticks", 16'(nt), 16'd0);
    check("pause_hold", disp_bcd, 16'h0009);
    press_ss();
    @(negedge clk);
    check("resume_tick_held_presc", {15'd0, tick}, 16'd1);
    press_ss();
    @(negedge clk);
    check("pause_again", disp_bcd, 16'h0010);
    press_lap();
    @(negedge clk);
    check("clear_disp", disp_bcd, 16'h0000);
    check("clear_running", {15'd0, running}, 16'd0);
    press_ss();
    wait_ticks(1);
    @(negedge clk);
    check("restart_from_zero", disp_bcd, 16'h0001);

    // 5: simultaneous presses, held button
    @(posedge clk); #1 begin btn_ss = 1'b1; btn_lap = 1'b1; end
    @(posedge clk); #1 begin btn_ss = 1'b0; btn_lap = 1'b0; end
    @(negedge clk);
    check("both_pressed_flags", {14'd0, running, lap_active}, 16'd0);
    @(posedge clk); #1 btn_ss = 1'b1;
    repeat (50) @(posedge clk);
    #1 btn_ss = 1'b0;
    @(negedge clk);
    check("held_one_transition", {15'd0, running}, 16'd1);

    // 6: held through reset, then reset mid-run at 12:34
    @(posedge clk); #1 begin reset = 1'b1; btn_ss = 1'b1; end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("held_through_reset", {15'd0, running}, 16'd0);
    btn_ss = 1'b0;
    press_ss();
    wait_ticks(754);
    @(negedge clk);
    check("reach_1234", disp_bcd, 16'h1234);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrun_reset_disp", disp_bcd, 16'h0000);
    check("midrun_reset_flags", {12'd0, running, lap_active, tick, wrap}, 16'h0000);
    @(posedge clk); #1 reset = 1'b0;

    // Randomized phase, checked every cycle by the scoreboard
    repeat (3000) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 5) == 0) btn_ss  = ~btn_ss;
      if ($urandom_range(0, 5) == 0) btn_lap = ~btn_lap;
      reset = ($urandom_range(0, 399) == 0);
    end
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
